// File: rtl/game_pkg.sv
// Shared types, widths and default timing constants for the game flow sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } game_state_t;

  localparam int unsigned DEF_FRAMES_PER_SEC = 60;
  localparam int unsigned DEF_GAME_TIME      = 99;
  localparam int unsigned DEF_START_LIVES    = 3;
  localparam int unsigned DEF_INVULN_FRAMES  = 90;
  localparam int unsigned DEF_END_HOLD_SEC   = 5;

  localparam int unsigned TIME_W  = 8;
  localparam int unsigned LIVES_W = 3;

  typedef logic [TIME_W-1:0]  time_t;
  typedef logic [LIVES_W-1:0] lives_t;

  // Bits needed for a counter spanning 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Event inputs from collision/frame logic and status outputs toward the overlay mux.
interface game_flow_controller_if;
  import game_pkg::*;

  logic   startOfFrame;
  logic   start_key;
  logic   player_hit;
  logic   exit_reached;
  logic   winner;
  logic   loser;
  logic   game_active;
  logic   invulnerable;
  logic   one_sec_tick;
  time_t  time_left;
  lives_t lives;

  modport master (
    output startOfFrame, start_key, player_hit, exit_reached,
    input  winner, loser, game_active, invulnerable, one_sec_tick, time_left, lives
  );

  modport slave (
    input  startOfFrame, start_key, player_hit, exit_reached,
    output winner, loser, game_active, invulnerable, one_sec_tick, time_left, lives
  );

endinterface

// File: rtl/frame_sec_divider.sv
// Counts start-of-frame pulses and emits a registered one-cycle tick every second.
module frame_sec_divider
  import game_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = DEF_FRAMES_PER_SEC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sof_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = cnt_width(FRAMES_PER_SEC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             wrap_c;

  // Clear restarts a full second and suppresses a coincident wrap.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    wrap_c = (cnt_q == CNT_W'(FRAMES_PER_SEC - 1));
    if (clr_i) begin
      cnt_d = '0;
    end else if (sof_i) begin
      if (wrap_c) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/game_flow_controller.sv
// IDLE/PLAY/WIN/LOSE sequencer: lives, countdown, hit immunity and end-screen hold.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
  parameter int unsigned GAME_TIME      = DEF_GAME_TIME,
  parameter int unsigned START_LIVES    = DEF_START_LIVES,
  parameter int unsigned INVULN_FRAMES  = DEF_INVULN_FRAMES,
  parameter int unsigned END_HOLD_SEC   = DEF_END_HOLD_SEC
) (
  input  logic                   clk,
  input  logic                   resetN,
  game_flow_controller_if.slave  gf
);

  localparam int unsigned INV_W  = cnt_width(INVULN_FRAMES + 1);
  localparam int unsigned HOLD_W = cnt_width(END_HOLD_SEC);

  game_state_t       state_q, state_d;
  logic              start_q;
  lives_t            lives_q, lives_d;
  time_t             time_q, time_d;
  logic [INV_W-1:0]  inv_q, inv_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              winner_q, loser_q, active_q, invuln_q;
  logic              sec_tick;
  logic              start_rise_c;
  logic              game_start_c;

  assign start_rise_c = gf.start_key & ~start_q;
  assign game_start_c = (state_q == IDLE) && start_rise_c;

  frame_sec_divider #(
    .FRAMES_PER_SEC (FRAMES_PER_SEC)
  ) u_sec_div (
    .clk    (clk),
    .rst_n  (resetN),
    .sof_i  (gf.startOfFrame),
    .clr_i  (game_start_c),
    .tick_o (sec_tick)
  );

  // Next-state and counter updates; exit outranks a lethal hit, which outranks timeout.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    time_d  = time_q;
    inv_d   = inv_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE: begin
        inv_d  = '0;
        hold_d = '0;
        if (start_rise_c) state_d = PLAY;
      end

      PLAY: begin
        if (gf.exit_reached) begin
          state_d = WIN;
          inv_d   = '0;
          hold_d  = '0;
        end else begin
          if (gf.player_hit && (inv_q == '0)) begin
            if (lives_q != '0) lives_d = lives_q - LIVES_W'(1);
            inv_d = INV_W'(INVULN_FRAMES);
          end else if (gf.startOfFrame && (inv_q != '0)) begin
            inv_d = inv_q - INV_W'(1);
          end
          if (sec_tick && (time_q != '0)) time_d = time_q - TIME_W'(1);
          if ((lives_d == '0) || (time_d == '0)) begin
            state_d = LOSE;
            inv_d   = '0;
            hold_d  = '0;
          end
        end
      end

      WIN, LOSE: begin
        if (sec_tick) begin
          if (hold_q == HOLD_W'(END_HOLD_SEC - 1)) begin
            state_d = IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Reload the game budget whenever IDLE is (re)entered.
    if (state_d == IDLE) begin
      lives_d = LIVES_W'(START_LIVES);
      time_d  = TIME_W'(GAME_TIME);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      lives_q  <= LIVES_W'(START_LIVES);
      time_q   <= TIME_W'(GAME_TIME);
      inv_q    <= '0;
      hold_q   <= '0;
      winner_q <= 1'b0;
      loser_q  <= 1'b0;
      active_q <= 1'b0;
      invuln_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= gf.start_key;
      lives_q  <= lives_d;
      time_q   <= time_d;
      inv_q    <= inv_d;
      hold_q   <= hold_d;
      winner_q <= (state_d == WIN);
      loser_q  <= (state_d == LOSE);
      active_q <= (state_d == PLAY);
      invuln_q <= (inv_d != '0);
    end
  end

  assign gf.winner       = winner_q;
  assign gf.loser        = loser_q;
  assign gf.game_active  = active_q;
  assign gf.invulnerable = invuln_q;
  assign gf.one_sec_tick = sec_tick;
  assign gf.time_left    = time_q;
  assign gf.lives        = lives_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed scenarios plus random play against a rule-level model.
module tb_game_flow_controller;

  localparam int FPS  = 4;
  localparam int GT   = 3;
  localparam int SL   = 2;
  localparam int INV  = 3;
  localparam int HOLD = 2;

  logic clk;
  logic resetN;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 0;

  game_flow_controller_if gf();

  game_flow_controller #(
    .FRAMES_PER_SEC (FPS),
    .GAME_TIME      (GT),
    .START_LIVES    (SL),
    .INVULN_FRAMES  (INV),
    .END_HOLD_SEC   (HOLD)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .gf     (gf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Rule-level model: game phase as a string-free code, counts as plain ints.
  localparam int PH_IDLE = 0, PH_PLAY = 1, PH_WIN = 2, PH_LOSE = 3;
  int m_phase, m_frames, m_lives, m_time, m_immune, m_secs_shown;
  bit m_tick, m_prev_key;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_phase = PH_IDLE; m_frames = 0; m_tick = 0; m_lives = SL; m_time = GT;
      m_immune = 0; m_secs_shown = 0; m_prev_key = 0;
    end else begin
      bit tick_seen, pressed, starting;
      tick_seen  = m_tick;
      pressed    = gf.start_key && !m_prev_key;
      m_prev_key = gf.start_key;
      starting   = (m_phase == PH_IDLE) && pressed;
      m_tick     = 0;
      if (starting) m_frames = 0;
      else if (gf.startOfFrame) begin
        m_frames = m_frames + 1;
        if (m_frames == FPS) begin m_frames = 0; m_tick = 1; end
      end
      if (m_phase == PH_IDLE) begin
        if (starting) m_phase = PH_PLAY;
      end else if (m_phase == PH_PLAY) begin
        if (gf.exit_reached) begin
          m_phase = PH_WIN; m_immune = 0; m_secs_shown = 0;
        end else begin
          if (gf.player_hit && m_immune == 0) begin
            m_lives  = (m_lives > 0) ? m_lives - 1 : 0;
            m_immune = INV;
          end else if (gf.startOfFrame && m_immune > 0) m_immune = m_immune - 1;
          if (tick_seen && m_time > 0) m_time = m_time - 1;
          if (m_lives == 0 || m_time == 0) begin
            m_phase = PH_LOSE; m_immune = 0; m_secs_shown = 0;
          end
        end
      end else if (tick_seen) begin
        m_secs_shown = m_secs_shown + 1;
        if (m_secs_shown == HOLD) begin m_phase = PH_IDLE; m_secs_shown = 0; end
      end
      if (m_phase == PH_IDLE) begin m_lives = SL; m_time = GT; m_immune = 0; end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_winner",       gf.winner,       32'(m_phase == PH_WIN));
      chk("m_loser",        gf.loser,        32'(m_phase == PH_LOSE));
      chk("m_game_active",  gf.game_active,  32'(m_phase == PH_PLAY));
      chk("m_invulnerable", gf.invulnerable, 32'(m_immune != 0));
      chk("m_one_sec_tick", gf.one_sec_tick, 32'(m_tick));
      chk("m_time_left",    gf.time_left,    32'(m_time));
      chk("m_lives",        gf.lives,        32'(m_lives));
    end
  end

  // Called at a negedge: present inputs for one edge, return at the next negedge.
  task automatic drive(input bit sof, input bit hit, input bit ex);
    gf.startOfFrame = sof; gf.player_hit = hit; gf.exit_reached = ex;
    @(negedge clk);
    gf.startOfFrame = 0; gf.player_hit = 0; gf.exit_reached = 0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin drive(1, 0, 0); drive(0, 0, 0); end
  endtask

  task automatic press_start();
    gf.start_key = 0; drive(0, 0, 0);
    gf.start_key = 1; drive(0, 0, 0);
  endtask

  initial begin
    gf.startOfFrame = 0; gf.start_key = 0; gf.player_hit = 0; gf.exit_reached = 0;
    resetN = 1'b1;
    #1 resetN = 1'b0;
    cmp_en = 1;
    @(negedge clk);
    chk("rst_time_left", gf.time_left, 3);
    chk("rst_lives", gf.lives, 2);
    chk("rst_game_active", gf.game_active, 0);
    #2 resetN = 1'b1;
    @(negedge clk);

    // Timeout run: countdown 3,2,1,0 then lose and hold two seconds.
    gf.start_key = 1; drive(0, 0, 0);
    chk("start_active", gf.game_active, 1);
    for (int f = 1; f <= 12; f++) begin
      drive(1, 0, 0);
      if (f % 4 == 0) chk("tick_on_4th_frame", gf.one_sec_tick, 1);
      drive(0, 0, 0);
      chk("countdown", gf.time_left, 32'(3 - f / 4));
    end
    chk("timeout_loser", gf.loser, 1);
    chk("timeout_inactive", gf.game_active, 0);
    frames(8);
    chk("hold_done_loser", gf.loser, 0);
    chk("hold_done_time", gf.time_left, 3);
    frames(3);
    chk("held_key_no_restart", gf.game_active, 0);
    press_start();
    chk("restart_active", gf.game_active, 1);
    chk("restart_time", gf.time_left, 3);
    chk("restart_lives", gf.lives, 2);

    // Two hits, second within immunity ignored, lethal hit five frames later.
    drive(0, 1, 0);
    chk("hit1_lives", gf.lives, 1);
    chk("hit1_invuln", gf.invulnerable, 1);
    drive(1, 0, 0);
    drive(0, 1, 0);
    chk("immune_hit_lives", gf.lives, 1);
    chk("immune_hit_invuln", gf.invulnerable, 1);
    drive(1, 0, 0);
    chk("immune_frame2", gf.invulnerable, 1);
    drive(1, 0, 0);
    chk("immune_expired", gf.invulnerable, 0);
    drive(1, 0, 0); drive(0, 0, 0);
    drive(1, 0, 0);
    drive(0, 1, 0);
    chk("lethal_lives", gf.lives, 0);
    chk("lethal_loser", gf.loser, 1);
    frames(12);
    chk("lethal_hold_done", gf.loser, 0);

    // Exit coincident with lethal hit: exit wins, lives not decremented.
    press_start();
    drive(0, 1, 0);
    frames(3);
    drive(0, 1, 1);
    chk("exit_winner", gf.winner, 1);
    chk("exit_loser", gf.loser, 0);
    chk("exit_lives", gf.lives, 1);
    frames(12);
    chk("win_hold_done", gf.winner, 0);

    // Asynchronous reset while immune mid-game.
    press_start();
    drive(0, 1, 0);
    chk("pre_reset_invuln", gf.invulnerable, 1);
    #2 resetN = 1'b0;
    #1;
    chk("async_rst_invuln", gf.invulnerable, 0);
    chk("async_rst_active", gf.game_active, 0);
    chk("async_rst_lives", gf.lives, 2);
    chk("async_rst_time", gf.time_left, 3);
    @(negedge clk);
    #2 resetN = 1'b1;
    @(negedge clk);
    gf.start_key = 0;

    // Randomized play against the model.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 19) == 0) gf.start_key = ~gf.start_key;
      gf.startOfFrame = ($urandom_range(0, 2) == 0);
      gf.player_hit   = ($urandom_range(0, 11) == 0);
      gf.exit_reached = ($urandom_range(0, 89) == 0);
      @(negedge clk);
    end
    gf.startOfFrame = 0; gf.player_hit = 0; gf.exit_reached = 0;
    @(negedge clk);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
